if_fetch_unit: RTL

//  Instruction-fetch stage of the MIPS32 pipeline. It holds the PC and issues one instruction-bus

---
 rtl/cpu_defs_pkg.sv | 20 ++
 rtl/if_fetch_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared MIPS32 pipeline definitions.
//   INST_NOP / RESET_PC   : default instruction word and reset PC
//   STALL_IFID / STALL_ID : bit indices into the 6-bit controller stall vector
//   fetch_state_t         : instruction-fetch controller states
package cpu_defs;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam int unsigned STALL_IFID = 1;
  localparam int unsigned STALL_ID   = 2;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DROP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one req/ack instruction-bus
// fetch at a time and presents {pc_o, inst_o} to the IF/ID register.
// Handles branch delay slots, exception flush and IF/ID back-pressure.
//   clk, rst          : clock, synchronous active-high reset
//   stall[5:0]        : controller stall vector ([1] IF/ID hold, [2] ID hold)
//   branch_flag_i/
//   branch_target_i   : taken branch in ID and its target
//   flush_i/new_pc_i  : exception/ERET flush pulse and restart PC
//   ibus_*            : instruction bus (req held until ack)
//   pc_o/inst_o       : PC and instruction for IF/ID
//   stallreq_o        : fetch not ready this cycle
module if_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [31:0] INST_NOP = cpu_defs::INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        stallreq_o
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic [31:0]  inst_buf, inst_buf_nx;
  logic         br_pend, br_pend_nx;
  logic [31:0]  br_tgt, br_tgt_nx;
  // Address of the abandoned fetch: pc is already the restart PC while the
  // stale request is drained, but the bus address must stay stable.
  logic [31:0]  drop_addr, drop_addr_nx;

  logic avail, accept, br_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FS_IDLE;
      pc        <= RESET_PC;
      inst_buf  <= INST_NOP;
      br_pend   <= 1'b0;
      br_tgt    <= '0;
      drop_addr <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      inst_buf  <= inst_buf_nx;
      br_pend   <= br_pend_nx;
      br_tgt    <= br_tgt_nx;
      drop_addr <= drop_addr_nx;
    end
  end

  always_comb begin
    avail  = ((state == FS_FETCH) && ibus_ack_i) || (state == FS_HOLD);
    accept = avail && !stall[STALL_IFID] && !flush_i;
    br_now = branch_flag_i && !stall[STALL_ID];

    ibus_req_o  = (state == FS_FETCH) || (state == FS_DROP);
    ibus_addr_o = (state == FS_DROP) ? drop_addr : pc;
    pc_o        = pc;
    inst_o      = INST_NOP;
    if (state == FS_HOLD)
      inst_o = inst_buf;
    else if (avail)
      inst_o = ibus_rdata_i;
    stallreq_o = (state == FS_IDLE) || (state == FS_DROP) ||
                 ((state == FS_FETCH) && !ibus_ack_i);

    state_nx     = state;
    pc_nx        = pc;
    inst_buf_nx  = inst_buf;
    br_pend_nx   = br_pend;
    br_tgt_nx    = br_tgt;
    drop_addr_nx = drop_addr;

    if (flush_i) begin
      pc_nx       = new_pc_i;
      br_pend_nx  = 1'b0;
      inst_buf_nx = INST_NOP;
      if ((state == FS_FETCH) && !ibus_ack_i) begin
        state_nx     = FS_DROP;
        drop_addr_nx = pc;
      end else if ((state == FS_DROP) && !ibus_ack_i) begin
        state_nx = FS_DROP;
      end else begin
        state_nx = FS_FETCH;
      end
    end else if (accept) begin
      // The accepted word is the delay slot; a pending branch takes
      // precedence over one arriving this cycle.
      if (br_pend)
        pc_nx = br_tgt;
      else if (br_now)
        pc_nx = branch_target_i;
      else
        pc_nx = pc + 32'd4;
      br_pend_nx = 1'b0;
      state_nx   = FS_FETCH;
    end else begin
      if (br_now) begin
        br_pend_nx = 1'b1;
        br_tgt_nx  = branch_target_i;
      end
      unique case (state)
        FS_IDLE:  state_nx = FS_FETCH;
        FS_FETCH: if (ibus_ack_i) begin
                    inst_buf_nx = ibus_rdata_i;
                    state_nx    = FS_HOLD;
                  end
        FS_HOLD:  state_nx = FS_HOLD;
        FS_DROP:  if (ibus_ack_i) state_nx = FS_FETCH;
        default:  state_nx = FS_IDLE;
      endcase
    end
  end

endmodule
